// File: rtl/risc_pkg.sv
// Shared defaults for the register-file datapath: word width, register count
// and address width.
package risc_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 16;
  localparam int RF_ADDR_W   = $clog2(RF_NUM_REGS);

endpackage

// File: rtl/reg_32_bit_rst.sv
// One storage word: a register with a load enable and an asynchronous
// active-low clear.
module reg_32_bit_rst #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_file_read.sv
// Register file with one write port and two registered read ports.
// A write and a read to the same address on one edge return the new data.
module register_file_read
  import risc_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              read_valid
);

  logic [NUM_REGS-1:0] load_p0;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   rd_a_p0;
  logic [DATA_W-1:0]   rd_b_p0;

  always_comb begin
    load_p0 = '0;
    if (write_enable) begin
      load_p0[write_addr] = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_word
    reg_32_bit_rst #(
      .WIDTH(DATA_W)
    ) u_word (
      .clk    (clk),
      .reset_n(reset_n),
      .load   (load_p0[i]),
      .d      (write_data),
      .q      (regs[i])
    );
  end

  // Stage p0: read muxes with write-port bypass, so a same-edge write wins.
  always_comb begin
    rd_a_p0 = regs[addr_a];
    rd_b_p0 = regs[addr_b];
    if (write_enable && (write_addr == addr_a)) begin
      rd_a_p0 = write_data;
    end
    if (write_enable && (write_addr == addr_b)) begin
      rd_b_p0 = write_data;
    end
  end

  // Stage p1: registered read data and its valid flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_a      <= '0;
      out_b      <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= read_enable;
      if (read_enable) begin
        out_a <= rd_a_p0;
        out_b <= rd_b_p0;
      end
    end
  end

endmodule

// File: tb/tb_register_file_read.sv
// Bench for register_file_read: directed scenarios followed by random traffic,
// all checked against an array-based reference of the register file.
module tb_register_file_read;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        write_enable;
  logic [3:0]  write_addr;
  logic [31:0] write_data;
  logic        read_enable;
  logic [3:0]  addr_a;
  logic [3:0]  addr_b;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        read_valid;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [16];
  logic [31:0] exp_a;
  logic [31:0] exp_b;
  logic        exp_v;

  register_file_read dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .write_enable(write_enable),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .read_enable (read_enable),
    .addr_a      (addr_a),
    .addr_b      (addr_b),
    .out_a       (out_a),
    .out_b       (out_b),
    .read_valid  (read_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".out_a"}, out_a, exp_a);
    chk({tag, ".out_b"}, out_b, exp_b);
    chk({tag, ".read_valid"}, {31'd0, read_valid}, {31'd0, exp_v});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    exp_a = 32'h0;
    exp_b = 32'h0;
    exp_v = 1'b0;
  endtask

  // One clock: drive inputs, predict from the register-file rules, check after the edge.
  task automatic cycle(input string tag, input logic we, input logic [3:0] wa,
                       input logic [31:0] wd, input logic re,
                       input logic [3:0] aa, input logic [3:0] ab);
    write_enable = we;
    write_addr   = wa;
    write_data   = wd;
    read_enable  = re;
    addr_a       = aa;
    addr_b       = ab;
    if (re) begin
      exp_a = (we && wa == aa) ? wd : mdl[aa];
      exp_b = (we && wa == ab) ? wd : mdl[ab];
    end
    exp_v = re;
    if (we) mdl[wa] = wd;
    @(posedge clk);
    #1;
    chk_outputs(tag);
  endtask

  initial begin
    reset_n      = 1'b0;
    write_enable = 1'b0;
    write_addr   = '0;
    write_data   = '0;
    read_enable  = 1'b0;
    addr_a       = '0;
    addr_b       = '0;
    model_reset();

    @(posedge clk);
    #1;
    chk_outputs("reset_init");
    @(negedge clk);
    reset_n = 1'b1;

    // First edge after reset is a normal edge: write R3, then read it.
    cycle("wr_r3", 1'b1, 4'd3, 32'h0000000A, 1'b0, 4'd0, 4'd0);
    cycle("rd_r3", 1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 4'd3);

    // Bypass on both ports, same address.
    cycle("wr_r7", 1'b1, 4'd7, 32'h0000000B, 1'b0, 4'd0, 4'd0);
    cycle("bypass_r7", 1'b1, 4'd7, 32'h0000000C, 1'b1, 4'd7, 4'd7);
    cycle("rd_r7_after", 1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 4'd3);

    // Hold while read_enable is low, even when the read register changes.
    cycle("hold_rd", 1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 4'd7);
    cycle("hold_wr", 1'b1, 4'd3, 32'hFFFFFFFF, 1'b0, 4'd3, 4'd3);
    cycle("hold_idle", 1'b0, 4'd0, 32'h0, 1'b0, 4'd3, 4'd3);

    // Sweep all registers, then back-to-back paired reads.
    for (int n = 0; n < 16; n++)
      cycle("sweep_wr", 1'b1, 4'(n), 32'(n) * 32'h11111111, 1'b0, 4'd0, 4'd0);
    for (int n = 0; n < 16; n++)
      cycle("sweep_rd", 1'b0, 4'd0, 32'h0, 1'b1, 4'(n), 4'(15 - n));

    // Address extremes must not alias.
    cycle("wr_r15", 1'b1, 4'd15, 32'hDEADBEEF, 1'b0, 4'd0, 4'd0);
    cycle("wr_r0", 1'b1, 4'd0, 32'h12345678, 1'b0, 4'd0, 4'd0);
    cycle("rd_15_0", 1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 4'd0);
    cycle("rd_0_15", 1'b0, 4'd0, 32'h0, 1'b1, 4'd0, 4'd15);

    // Write immediately followed by a read of the same address.
    cycle("wr_r9", 1'b1, 4'd9, 32'hCAFEF00D, 1'b0, 4'd0, 4'd0);
    cycle("rd_r9", 1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 4'd9);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      cycle("random", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    // Mid-cycle asynchronous reset with a pending write and read on the inputs.
    cycle("pre_reset", 1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 4'd0);
    cycle("pre_reset2", 1'b1, 4'd15, 32'hA5A5A5A5, 1'b1, 4'd15, 4'd15);
    write_enable = 1'b1;
    write_addr   = 4'd5;
    write_data   = 32'h55555555;
    read_enable  = 1'b1;
    addr_a       = 4'd5;
    addr_b       = 4'd15;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_outputs("async_reset");
    @(posedge clk);
    #1;
    chk_outputs("reset_held");
    @(negedge clk);
    reset_n = 1'b1;

    cycle("post_rst_r5", 1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 4'd15);
    for (int n = 0; n < 16; n += 2)
      cycle("post_rst_all", 1'b0, 4'd0, 32'h0, 1'b1, 4'(n), 4'(n + 1));
    cycle("post_rst_wr", 1'b1, 4'd5, 32'h0BADC0DE, 1'b1, 4'd5, 4'd5);
    cycle("post_rst_rd", 1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 4'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_read.md
REGISTER_FILE_READ -- requirements
Module: register_file_read

Interface
REQ-001 Parameter: DATA_W, 32, width of each register and of every data port.
REQ-002 Parameter: NUM_REGS, 16, number of architectural registers.
REQ-003 Parameter: ADDR_W, 4, register address width; SHALL equal log2(NUM_REGS).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 write_enable  input  1  write strobe for the write port.
REQ-007 write_addr  input  ADDR_W  register written when write_enable=1.
REQ-008 write_data  input  DATA_W  value written.
REQ-009 read_enable  input  1  request to sample both read ports this cycle.
REQ-010 addr_a  input  ADDR_W  read port A address.
REQ-011 addr_b  input  ADDR_W  read port B address.
REQ-012 out_a  output  DATA_W  registered read data, port A.
REQ-013 out_b  output  DATA_W  registered read data, port B.
REQ-014 read_valid  output  1  high for exactly the cycle after a cycle with read_enable=1.

Function
REQ-015 On a rising clk edge with write_enable=1, regs[write_addr] SHALL take write_data; all other registers SHALL hold.
REQ-016 All NUM_REGS registers SHALL be writable; none is hardwired.
REQ-017 On a rising clk edge with read_enable=1, out_a SHALL take regs[addr_a] and out_b SHALL take regs[addr_b]; read latency is 1 cycle.
REQ-018 With read_enable=0, out_a and out_b SHALL hold their previous values.
REQ-019 read_valid SHALL be a registered copy of read_enable.
REQ-020 Bypass rule: if write_enable=1, read_enable=1, and write_addr==addr_a on the same edge, out_a SHALL take write_data rather than the old register value; port B follows the same rule.
REQ-021 addr_a==addr_b SHALL return identical data on both ports, including under bypass.
REQ-022 Back-to-back read_enable cycles SHALL each produce new data, with read_valid held high continuously.
REQ-023 Writes and reads to the same address on consecutive cycles SHALL return the newly written value, with no stale window.

Reset
REQ-024 reset_n=0 SHALL immediately clear all registers, out_a, out_b and read_valid to 0, regardless of clk.
REQ-025 Reset asserted in the middle of operation SHALL discard any write or read captured in that cycle.
REQ-026 The first rising edge after reset_n rises SHALL be a normal operating edge.

Structure
REQ-027 DATA_W, NUM_REGS and ADDR_W defaults SHALL live in the shared package risc_pkg.
REQ-028 Each storage word SHALL be an instance of sub-module reg_32_bit_rst: a 32-bit register with load enable and an asynchronous active-low clear.
REQ-029 Per-register load enables SHALL come from a one-hot decode of write_addr gated by write_enable.
REQ-030 Read muxes and bypass compare logic SHALL be combinational and feed the output registers.

Verification
REQ-031 Reset: drive reset_n=0 mid-cycle after writes -> out_a=out_b=0 and read_valid=0 immediately, then a read of R5 returns 0x00000000.
REQ-032 Write then read: write R3=0x0000000A, next cycle read_enable with addr_a=3 -> out_a=0x0000000A and read_valid=1 one cycle later.
REQ-033 Bypass: R7 holds 0x0000000B; on the same edge write R7=0x0000000C and read addr_a=addr_b=7 -> out_a=out_b=0x0000000C.
REQ-034 Hold: read R3 (0x0000000A), then read_enable=0 while writing R3=0xFFFFFFFF -> out_a stays 0x0000000A and read_valid drops to 0.
REQ-035 Sweep: write Rn=n*0x11111111 for n=0..15, then read pairs (n, 15-n) back-to-back -> correct values each cycle with read_valid continuously 1.
REQ-036 Boundary: write R15=0xDEADBEEF and R0=0x12345678 -> reads of addresses 15 and 0 return those values with no aliasing.
